// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register controller.
// Register-file depth default, transaction direction encoding and the FSM states.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PTR,
        WRITE,
        READ
    } i2c_state_e;

    localparam int unsigned DEFAULT_NUM_REGS = 16;
    localparam logic        I2C_RW_READ      = 1'b1;

endpackage

// File: rtl/i2c_reg_ctrl_if.sv
// Byte-level I2C peripheral events plus the local fabric access port.
// The master modport is the peripheral/fabric side; the slave modport is the controller.
interface i2c_reg_ctrl_if #(
    parameter int unsigned AW = 4
);

    logic          i2c_start;
    logic          i2c_rw;
    logic          i2c_stop;
    logic          i2c_rx_valid;
    logic [7:0]    i2c_rx_data;
    logic          i2c_tx_req;
    logic [7:0]    i2c_tx_data;
    logic          i2c_tx_valid;

    logic          loc_req;
    logic          loc_we;
    logic [AW-1:0] loc_addr;
    logic [7:0]    loc_wdata;
    logic          loc_gnt;
    logic [7:0]    loc_rdata;
    logic          loc_rvalid;

    modport master (
        output i2c_start, i2c_rw, i2c_stop, i2c_rx_valid, i2c_rx_data, i2c_tx_req,
        output loc_req, loc_we, loc_addr, loc_wdata,
        input  i2c_tx_data, i2c_tx_valid, loc_gnt, loc_rdata, loc_rvalid
    );

    modport slave (
        input  i2c_start, i2c_rw, i2c_stop, i2c_rx_valid, i2c_rx_data, i2c_tx_req,
        input  loc_req, loc_we, loc_addr, loc_wdata,
        output i2c_tx_data, i2c_tx_valid, loc_gnt, loc_rdata, loc_rvalid
    );

endinterface

// File: rtl/i2c_regfile.sv
// NUM_REGS x 8 register file: one write port, one registered read port.
// A read in the same cycle as a write to the same address returns the old value.
module i2c_regfile
    import i2c_pkg::*;
#(
    parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
    parameter int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [NUM_REGS-1:0][7:0] regs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs  <= '0;
            rdata <= 8'h00;
        end else begin
            if (we) begin
                regs[waddr] <= wdata;
            end
            if (re) begin
                rdata <= regs[raddr];
            end
        end
    end

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Turns the I2C peripheral byte stream into pointer/auto-increment register accesses,
// sharing the register file with a local port that yields to I2C traffic.
module i2c_reg_ctrl
    import i2c_pkg::*;
#(
    parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
    parameter int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic           clk,
    input  logic           rst,
    i2c_reg_ctrl_if.slave  bus,
    output logic           wr_pulse,
    output logic [AW-1:0]  wr_addr,
    output logic           busy
);

    i2c_state_e    state;
    logic [AW-1:0] ptr;

    logic          i2c_wr;
    logic          i2c_rd;
    logic          i2c_access;
    logic          loc_wr;
    logic          loc_rd;

    logic          rf_we;
    logic          rf_re;
    logic [AW-1:0] rf_waddr;
    logic [AW-1:0] rf_raddr;
    logic [7:0]    rf_wdata;
    logic [7:0]    rf_rdata;

    logic          tx_valid_q;
    logic          loc_rvalid_q;
    logic [7:0]    tx_hold_q;
    logic [7:0]    loc_hold_q;

    // A coincident START drops the byte or request, so it is not an access.
    always_comb begin
        i2c_wr     = ~bus.i2c_start & bus.i2c_rx_valid & (state == WRITE);
        i2c_rd     = ~bus.i2c_start & bus.i2c_tx_req & (state == READ);
        i2c_access = i2c_wr | i2c_rd;
        loc_wr     = bus.loc_gnt & bus.loc_we;
        loc_rd     = bus.loc_gnt & ~bus.loc_we;
        rf_we      = i2c_wr | loc_wr;
        rf_waddr   = i2c_wr ? ptr : bus.loc_addr;
        rf_wdata   = i2c_wr ? bus.i2c_rx_data : bus.loc_wdata;
        rf_re      = i2c_rd | loc_rd;
        rf_raddr   = i2c_rd ? ptr : bus.loc_addr;
    end

    assign bus.loc_gnt = bus.loc_req & ~i2c_access & ~rst;

    i2c_regfile #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (rf_we),
        .waddr (rf_waddr),
        .wdata (rf_wdata),
        .re    (rf_re),
        .raddr (rf_raddr),
        .rdata (rf_rdata)
    );

    // The shared read register feeds whichever side read last; each side keeps its own copy.
    assign bus.i2c_tx_valid = tx_valid_q;
    assign bus.i2c_tx_data  = tx_valid_q ? rf_rdata : tx_hold_q;
    assign bus.loc_rvalid   = loc_rvalid_q;
    assign bus.loc_rdata    = loc_rvalid_q ? rf_rdata : loc_hold_q;
    assign busy             = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            tx_valid_q   <= 1'b0;
            loc_rvalid_q <= 1'b0;
            tx_hold_q    <= 8'h00;
            loc_hold_q   <= 8'h00;
            wr_pulse     <= 1'b0;
            wr_addr      <= '0;
        end else begin
            tx_valid_q   <= i2c_rd;
            loc_rvalid_q <= loc_rd;
            wr_pulse     <= rf_we;
            if (rf_we) begin
                wr_addr <= rf_waddr;
            end
            if (tx_valid_q) begin
                tx_hold_q <= rf_rdata;
            end
            if (loc_rvalid_q) begin
                loc_hold_q <= rf_rdata;
            end

            if (bus.i2c_start) begin
                state <= (bus.i2c_rw == I2C_RW_READ) ? READ : PTR;
            end else begin
                case (state)
                    PTR: begin
                        if (bus.i2c_rx_valid) begin
                            ptr   <= bus.i2c_rx_data[AW-1:0];
                            state <= WRITE;
                        end
                    end
                    WRITE: begin
                        if (i2c_wr) begin
                            ptr <= ptr + AW'(1);
                        end
                    end
                    READ: begin
                        if (i2c_rd) begin
                            ptr <= ptr + AW'(1);
                        end
                    end
                    default: ;
                endcase
                // STOP still lets a same-cycle WRITE byte land before going idle.
                if (bus.i2c_stop) begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule
